// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone register-bus initiator.
package wb_initiator_pkg;

    // Transfer sequencer states: waiting for a command, bus cycle open, response pending.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    // Byte-select width of the fabric register bus.
    localparam int WB_BE_W = 4;

    // Read data reported when a transfer times out or is rejected.
    localparam logic [31:0] WB_TIMEOUT_RD_VALUE = 32'hBADFABAC;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Counts bus cycles spent waiting for an acknowledge and flags expiry.
module wb_ack_watchdog
    import wb_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] cnt;

    // Wait counter: cleared when a transfer starts, advances on each un-acknowledged cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Expire on the edge where the count would reach TIMEOUT_CYCLES; a zero timeout never expires.
    always_comb begin
        expire = 1'b0;
        if (TIMEOUT_CYCLES != 0) begin
            expire = enable && (cnt == LAST);
        end
    end

endmodule

// File: rtl/wb_initiator_seq.sv
// Single-transfer Wishbone initiator: command in, one bus cycle, response out.
module wb_initiator_seq
    import wb_initiator_pkg::*;
#(
    parameter int                    APERWIDTH        = 17,
    parameter int                    DATAWIDTH        = 32,
    parameter int                    TIMEOUT_CYCLES   = 15,
    parameter logic [DATAWIDTH-1:0]  TIMEOUT_RD_VALUE = DATAWIDTH'(WB_TIMEOUT_RD_VALUE)
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [APERWIDTH-1:0] cmd_addr,
    input  logic [WB_BE_W-1:0]   cmd_be,
    input  logic [DATAWIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [APERWIDTH-1:0] WBs_ADR,
    output logic                 WBs_CYC,
    output logic                 WBs_STB,
    output logic                 WBs_WE,
    output logic                 WBs_RD,
    output logic [WB_BE_W-1:0]   WBs_BYTE_STB,
    output logic [DATAWIDTH-1:0] WBs_WR_DAT,
    input  logic [DATAWIDTH-1:0] WBs_RD_DAT,
    input  logic                 WBs_ACK
);

    wb_state_t state, state_n;

    logic                 cmd_ready_n;
    logic                 rsp_valid_n;
    logic [DATAWIDTH-1:0] rsp_rdata_n;
    logic                 rsp_err_n;
    logic [APERWIDTH-1:0] adr_n;
    logic                 cyc_n;
    logic                 stb_n;
    logic                 we_n;
    logic                 rd_n;
    logic [WB_BE_W-1:0]   be_n;
    logic [DATAWIDTH-1:0] wdat_n;

    logic accept;
    logic ack_seen;
    logic wd_enable;
    logic wd_expire;

    assign accept    = cmd_valid && cmd_ready;
    assign ack_seen  = WBs_ACK && WBs_STB;
    assign wd_enable = (state == BUS) && !ack_seen;

    wb_ack_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (WB_CLK),
        .rst   (WB_RST),
        .clear (accept),
        .enable(wd_enable),
        .expire(wd_expire)
    );

    // State and every output are registered; reset clears all of them, cmd_ready included.
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state        <= IDLE;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            WBs_ADR      <= '0;
            WBs_CYC      <= 1'b0;
            WBs_STB      <= 1'b0;
            WBs_WE       <= 1'b0;
            WBs_RD       <= 1'b0;
            WBs_BYTE_STB <= '0;
            WBs_WR_DAT   <= '0;
        end else begin
            state        <= state_n;
            cmd_ready    <= cmd_ready_n;
            rsp_valid    <= rsp_valid_n;
            rsp_rdata    <= rsp_rdata_n;
            rsp_err      <= rsp_err_n;
            WBs_ADR      <= adr_n;
            WBs_CYC      <= cyc_n;
            WBs_STB      <= stb_n;
            WBs_WE       <= we_n;
            WBs_RD       <= rd_n;
            WBs_BYTE_STB <= be_n;
            WBs_WR_DAT   <= wdat_n;
        end
    end

    // Next state and next output values; handshake flags follow the state being entered.
    always_comb begin
        state_n     = state;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        adr_n       = WBs_ADR;
        cyc_n       = WBs_CYC;
        stb_n       = WBs_STB;
        we_n        = WBs_WE;
        rd_n        = WBs_RD;
        be_n        = WBs_BYTE_STB;
        wdat_n      = WBs_WR_DAT;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_be != '0) begin
                        adr_n   = cmd_addr;
                        be_n    = cmd_be;
                        wdat_n  = cmd_wdata;
                        cyc_n   = 1'b1;
                        stb_n   = 1'b1;
                        we_n    = cmd_we;
                        rd_n    = !cmd_we;
                        state_n = BUS;
                    end else begin
                        rsp_err_n   = 1'b1;
                        rsp_rdata_n = TIMEOUT_RD_VALUE;
                        state_n     = RESP;
                    end
                end
            end
            BUS: begin
                // Acknowledge takes priority over a watchdog expiry on the same edge.
                if (ack_seen) begin
                    rsp_rdata_n = WBs_WE ? '0 : WBs_RD_DAT;
                    rsp_err_n   = 1'b0;
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    we_n        = 1'b0;
                    rd_n        = 1'b0;
                    be_n        = '0;
                    state_n     = RESP;
                end else if (wd_expire) begin
                    rsp_rdata_n = TIMEOUT_RD_VALUE;
                    rsp_err_n   = 1'b1;
                    cyc_n       = 1'b0;
                    stb_n       = 1'b0;
                    we_n        = 1'b0;
                    rd_n        = 1'b0;
                    be_n        = '0;
                    state_n     = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        cmd_ready_n = (state_n == IDLE);
        rsp_valid_n = (state_n == RESP);
    end

endmodule
